// File: rtl/vga_timing_gen.sv
// 1024x768@60 VGA raster timing: registered h/v counters with aligned sync/blank flags.
// Optional frame-start pulse at pixel (0,0) enabled by VGA_TIMING_FRAME_START_EN.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 1024,
    parameter int unsigned H_FP     = 24,
    parameter int unsigned H_SYNC   = 136,
    parameter int unsigned H_BP     = 160,
    parameter int unsigned V_ACTIVE = 768,
    parameter int unsigned V_FP     = 3,
    parameter int unsigned V_SYNC   = 6,
    parameter int unsigned V_BP     = 29
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    output logic [11:0] hcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic [11:0] vcount_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_start_out
);

    localparam logic [11:0] H_LAST     = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] H_BLK      = 12'(H_ACTIVE);
    localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [11:0] V_LAST     = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [11:0] V_BLK      = 12'(V_ACTIVE);
    localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);

    logic [11:0] h_nxt;
    logic [11:0] v_nxt;

    // Flags decode the next count so they land on the same edge as the count.
    always_comb begin
        h_nxt = hcount_out + 12'd1;
        v_nxt = vcount_out;
        if (hcount_out == H_LAST) begin
            h_nxt = '0;
            if (vcount_out == V_LAST) begin
                v_nxt = '0;
            end else begin
                v_nxt = vcount_out + 12'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            hcount_out <= '0;
            vcount_out <= '0;
            hsync_out  <= 1'b0;
            hblnk_out  <= 1'b0;
            vsync_out  <= 1'b0;
            vblnk_out  <= 1'b0;
        end else if (ce) begin
            hcount_out <= h_nxt;
            vcount_out <= v_nxt;
            hblnk_out  <= (h_nxt >= H_BLK);
            hsync_out  <= (h_nxt >= H_SYNC_BEG) && (h_nxt < H_SYNC_END);
            vblnk_out  <= (v_nxt >= V_BLK);
            vsync_out  <= (v_nxt >= V_SYNC_BEG) && (v_nxt < V_SYNC_END);
        end
    end

`ifdef VGA_TIMING_FRAME_START_EN
    logic frame_start_q;

    // Reset parks at (0,0) without pulsing; only a counted wrap into (0,0) sets it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            frame_start_q <= 1'b0;
        end else if (ce) begin
            frame_start_q <= (h_nxt == '0) && (v_nxt == '0);
        end
    end

    assign frame_start_out = frame_start_q;
`else
    assign frame_start_out = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: default horizontal timing, shortened vertical
// timing so full frames fit a short run; frame-start checks follow VGA_TIMING_FRAME_START_EN.
module tb_vga_timing_gen;

    localparam int unsigned HT    = 1344;
    localparam int unsigned VA    = 6;
    localparam int unsigned VFP   = 2;
    localparam int unsigned VS    = 3;
    localparam int unsigned VBP   = 2;
    localparam int unsigned VT    = VA + VFP + VS + VBP;   // 13 lines
    localparam int unsigned FRAME = HT * VT;               // 17472 ce edges
`ifdef VGA_TIMING_FRAME_START_EN
    localparam bit FS_EN = 1'b1;
`else
    localparam bit FS_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        ce;
    logic [11:0] hcount_out;
    logic        hsync_out;
    logic        hblnk_out;
    logic [11:0] vcount_out;
    logic        vsync_out;
    logic        vblnk_out;
    logic        frame_start_out;

    vga_timing_gen #(
        .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce),
        .hcount_out(hcount_out), .hsync_out(hsync_out), .hblnk_out(hblnk_out),
        .vcount_out(vcount_out), .vsync_out(vsync_out), .vblnk_out(vblnk_out),
        .frame_start_out(frame_start_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {fs, vblnk, vsync, hblnk, hsync, vcount, hcount}
    logic [28:0] act;
    assign act = {frame_start_out, vblnk_out, vsync_out, hblnk_out, hsync_out,
                  vcount_out, hcount_out};

    typedef struct {
        int unsigned n;
        logic [11:0] h;
        logic [11:0] v;
        logic        hs;
        logic        hb;
        logic        vs;
        logic        vb;
    } vec_t;

    vec_t        tbl[9];
    int unsigned total;
    int unsigned passed;
    int unsigned k;
    int unsigned errs, hs_cnt, vs_cnt, vb_cnt, fs_cnt;
    logic [28:0] first_bad_act, first_bad_exp;

    function automatic logic [28:0] pack(logic [11:0] h, logic [11:0] v, logic hs, logic hb,
                                         logic vs, logic vb, logic fs);
        return {fs, vb, vs, hb, hs, v, h};
    endfunction

    // Expected outputs after kk ce edges since reset, from the raster definition.
    function automatic logic [28:0] model(int unsigned kk);
        int unsigned h, v;
        logic fs;
        h  = kk % HT;
        v  = (kk / HT) % VT;
        fs = FS_EN && (kk != 0) && (kk % FRAME == 0);
        return pack(12'(h), 12'(v), (h >= 1048) && (h < 1184), h >= 1024,
                    (v >= VA + VFP) && (v < VA + VFP + VS), v >= VA, fs);
    endfunction

    task automatic check(input string name, input logic [28:0] a, input logic [28:0] e);
        total++;
        if (a === e) passed++;
        else $display("FAIL %s: got %h expected %h", name, a, e);
    endtask

    task automatic check_int(input string name, input int unsigned a, input int unsigned e);
        total++;
        if (a == e) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, a, e);
    endtask

    task automatic do_reset(input int unsigned n);
        rst = 1'b0;
        ce  = 1'b1;
        repeat (n) begin
            @(posedge clk); #1;
            check("reset_zero", act, '0);
        end
        rst = 1'b1;
        k   = 0;
    endtask

    task automatic scan(input int unsigned nclk, input bit gated);
        logic [28:0] e;
        errs = 0; hs_cnt = 0; vs_cnt = 0; vb_cnt = 0; fs_cnt = 0;
        for (int unsigned i = 0; i < nclk; i++) begin
            ce = gated ? (i % 2 == 0) : 1'b1;
            @(posedge clk); #1;
            if (ce) begin
                k++;
                hs_cnt += 32'(hsync_out);
                vs_cnt += 32'(vsync_out);
                vb_cnt += 32'(vblnk_out);
                fs_cnt += 32'(frame_start_out);
            end
            e = model(k);
            if (act !== e) begin
                if (errs == 0) begin
                    first_bad_act = act;
                    first_bad_exp = e;
                end
                errs++;
            end
        end
        ce = 1'b1;
    endtask

    initial begin
        total = 0; passed = 0; k = 0;
        rst = 1'b0; ce = 1'b0;

        tbl[0] = '{1,    12'd1,    12'd0, 0, 0, 0, 0};
        tbl[1] = '{1022, 12'd1023, 12'd0, 0, 0, 0, 0};
        tbl[2] = '{1,    12'd1024, 12'd0, 0, 1, 0, 0};
        tbl[3] = '{23,   12'd1047, 12'd0, 0, 1, 0, 0};
        tbl[4] = '{1,    12'd1048, 12'd0, 1, 1, 0, 0};
        tbl[5] = '{135,  12'd1183, 12'd0, 1, 1, 0, 0};
        tbl[6] = '{1,    12'd1184, 12'd0, 0, 1, 0, 0};
        tbl[7] = '{159,  12'd1343, 12'd0, 0, 1, 0, 0};
        tbl[8] = '{1,    12'd0,    12'd1, 0, 0, 0, 0};

        do_reset(5);

        for (int unsigned t = 0; t < 9; t++) begin
            repeat (tbl[t].n) @(posedge clk);
            #1;
            k += tbl[t].n;
            check($sformatf("line_vec%0d", t), act,
                  pack(tbl[t].h, tbl[t].v, tbl[t].hs, tbl[t].hb, tbl[t].vs, tbl[t].vb, 1'b0));
        end

        // Full frame at ce=1 from reset, ending back at (0,0).
        do_reset(1);
        scan(FRAME, 1'b0);
        check_int("frame_mismatches", errs, 0);
        if (errs != 0) check("frame_first_bad", first_bad_act, first_bad_exp);
        check_int("frame_hsync_edges", hs_cnt, 136 * VT);
        check_int("frame_vsync_edges", vs_cnt, VS * HT);
        check_int("frame_vblnk_edges", vb_cnt, (VT - VA) * HT);
        check_int("frame_fs_pulses", fs_cnt, FS_EN ? 1 : 0);
        check("frame_end", act, pack(12'd0, 12'd0, 0, 0, 0, 0, FS_EN));

        // 1-of-2 ce pattern: one frame takes exactly 2*FRAME clocks, holds on ce=0.
        scan(2 * FRAME, 1'b1);
        check_int("gated_mismatches", errs, 0);
        if (errs != 0) check("gated_first_bad", first_bad_act, first_bad_exp);
        check_int("gated_hsync_edges", hs_cnt, 136 * VT);
        check_int("gated_fs_pulses", fs_cnt, FS_EN ? 1 : 0);
        check("gated_end", act, pack(12'd0, 12'd0, 0, 0, 0, 0, FS_EN));

        // Mid-frame reset at (500,7).
        scan(7 * HT + 500, 1'b0);
        check("mid_pos", act, pack(12'd500, 12'd7, 0, 0, 0, 1, 0));
        do_reset(1);
        @(posedge clk); #1;
        check("post_reset_first", act, pack(12'd1, 12'd0, 0, 0, 0, 0, 0));

        // ce=0 after reset: everything holds.
        ce = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("ce_hold", act, pack(12'd1, 12'd0, 0, 0, 0, 0, 0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Generates 1024x768 @ 60 Hz VGA raster timing: horizontal/vertical pixel counters plus registered sync and blanking flags. Sits directly upstream of the background-drawing stage and drives its `hcount/hsync/hblnk/vcount/vsync/vblnk` inputs. All outputs come from registers and are mutually aligned, so every downstream stage sees a consistent pixel position.

## Interface
- `H_ACTIVE`, 1024: visible pixels per line
- `H_FP`, 24: horizontal front porch, pixels
- `H_SYNC`, 136: horizontal sync width, pixels
- `H_BP`, 160: horizontal back porch, pixels
- `V_ACTIVE`, 768: visible lines per frame
- `V_FP`, 3: vertical front porch, lines
- `V_SYNC`, 6: vertical sync width, lines
- `V_BP`, 29: vertical back porch, lines
- `clk`  in  1  pixel-domain clock (65 MHz nominal)
- `rst`  in  1  reset, synchronous, active-low (0 = reset)
- `ce`  in  1  pixel advance enable; counters step only when 1
- `hcount_out`  out  12  horizontal position, 0..H_TOTAL-1
- `hsync_out`  out  1  1 during horizontal sync pulse
- `hblnk_out`  out  1  1 outside visible columns
- `vcount_out`  out  12  vertical position, 0..V_TOTAL-1
- `vsync_out`  out  1  1 during vertical sync pulse
- `vblnk_out`  out  1  1 outside visible lines
- `frame_start_out`  out  1  one-`ce` pulse at pixel (0,0); see Configuration

## Operation
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1344); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (806).
- On each `clk` edge with `rst`=1 and `ce`=1:
  - hcount advances by 1.
  - At H_TOTAL-1, hcount wraps to 0 and vcount advances by 1.
  - When vcount is V_TOTAL-1 at that same wrap, vcount also wraps to 0.
- With `ce`=0, every output holds its value.
- Flag decode. Each flag is a function of the *next* count value and is registered in the same edge as the count, so flag and count always describe the same pixel:
  - hblnk = h ≥ H_ACTIVE
  - hsync = H_ACTIVE+H_FP ≤ h < H_ACTIVE+H_FP+H_SYNC, i.e. 1048..1183
  - vblnk = v ≥ V_ACTIVE
  - vsync = V_ACTIVE+V_FP ≤ v < V_ACTIVE+V_FP+V_SYNC, i.e. 771..776
- Polarity: sync flags are logical (1 = pulse). Pin-polarity inversion is done at the top level, not here.
- Arithmetic: 12-bit unsigned counters. Compares use constants derived from the parameters; no subtraction at run time.
- The counters are the only state; there is no explicit FSM. The h/v counter pair forms the raster state.

## Timing
- Reset (`rst`=0 at an edge): all outputs go to 0 at that edge, including `frame_start_out`. This applies at any point, mid-line or mid-frame; there is no partial-frame recovery.
- First edge after reset release with `ce`=1: hcount_out=1, vcount_out=0. Pixel (0,0) is the reset state.
- Latency: a flag change is visible on the same edge as the count that causes it (0 cycles relative to the counts).
- Line wrap: the edge taking hcount 1343→0 also steps vcount. Both update together; there is never an intermediate (0, old v) state.
- Frame wrap: the edge taking (1343,805) produces (0,0), with vblnk_out=0, hblnk_out=0 and vsync_out=0.
- `ce` may toggle on any cycle. A held `ce`=0 across a wrap point simply delays that wrap.

## Configuration
- Macro: `VGA_TIMING_FRAME_START_EN`.
- Defined: `frame_start_out` is registered.
  - It goes to 1 on the `ce` edge that produces (0,0), and clears on the next `ce` edge.
  - It holds while `ce`=0.
  - It is 0 in reset. The reset-state (0,0) does not pulse; the first pulse comes at the first frame wrap.
- Undefined: `frame_start_out` is tied to constant 0 and no pulse logic is synthesized.

## Test plan
- **Reset release:** hold `rst`=0 for 5 cycles, then release with `ce`=1 → all outputs 0 during reset; first edge gives hcount=1, vcount=0, all flags 0.
- **Line decode:** run one line → hblnk_out rises at hcount=1024; hsync_out is 1 for hcount 1048..1183 (136 edges); hcount wraps 1343→0 while vcount goes 0→1 on the same edge.
- **Frame decode:** run one full frame (1,083,264 `ce` edges) → vblnk_out is 1 for vcount 768..805; vsync_out is 1 for vcount 771..776; the frame returns to (0,0).
- **ce gating:** drive `ce` as a 1-of-2 pattern → every output is stable on `ce`=0 cycles; the frame takes exactly 2×1,083,264 clocks.
- **Mid-frame reset:** assert `rst`=0 at (500,400) for 1 cycle → the next edge shows all outputs 0; counting restarts from (0,0).
- **Macro on:** with `VGA_TIMING_FRAME_START_EN`, frame_start_out is 1 for exactly one `ce` edge per frame, coincident with (0,0), and 0 after reset release. Macro off: frame_start_out is 0 throughout.
